// File: rtl/reg_file_cc.sv
// LC-3 register file: destination select, eight GPRs with two combinational read ports,
// NZP condition codes and the BEN branch-enable flop. Writes land on the rising edge; reads never bypass.
module reg_file_cc #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [15:0]       ir,
   input  logic [DATA_W-1:0] bus,
   input  logic [2:0]        sr1_addr,
   input  logic              DRMUX,
   input  logic              LD_REG,
   input  logic              LD_CC,
   input  logic              LD_BEN,
   output logic [DATA_W-1:0] sr1_out,
   output logic [DATA_W-1:0] sr2_out,
   output logic [2:0]        nzp,
   output logic              ben
);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [2:0]        nzp_q, nzp_d;
   logic              ben_q, ben_d;
   logic [2:0]        dr;

   // Opcode and immediate fields are decoded elsewhere; only the register fields matter here.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[15:12], ir[8:3]};

   assign dr = DRMUX ? 3'b111 : ir[11:9];

   always_comb begin
      nzp_d = 3'b001;
      if (bus[DATA_W-1]) begin
         nzp_d = 3'b100;
      end else if (bus == '0) begin
         nzp_d = 3'b010;
      end
   end

   // BEN looks at the registered nzp, so a same-cycle LD_CC is not seen.
   assign ben_d = (ir[11] & nzp_q[2]) | (ir[10] & nzp_q[1]) | (ir[9] & nzp_q[0]);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         nzp_q <= 3'b000;
         ben_q <= 1'b0;
      end else begin
         if (LD_REG) begin
            regs_q[dr] <= bus;
         end
         if (LD_CC) begin
            nzp_q <= nzp_d;
         end
         if (LD_BEN) begin
            ben_q <= ben_d;
         end
      end
   end

   assign sr1_out = regs_q[sr1_addr];
   assign sr2_out = regs_q[ir[2:0]];
   assign nzp     = nzp_q;
   assign ben     = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Directed self-checking bench for reg_file_cc.
module tb_reg_file_cc;

   logic        Clk;
   logic        Reset;
   logic [15:0] ir;
   logic [15:0] bus;
   logic [2:0]  sr1_addr;
   logic        DRMUX;
   logic        LD_REG;
   logic        LD_CC;
   logic        LD_BEN;
   logic [15:0] sr1_out;
   logic [15:0] sr2_out;
   logic [2:0]  nzp;
   logic        ben;

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_cc #(.DATA_W(16), .NREG(8)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ir       (ir),
      .bus      (bus),
      .sr1_addr (sr1_addr),
      .DRMUX    (DRMUX),
      .LD_REG   (LD_REG),
      .LD_CC    (LD_CC),
      .LD_BEN   (LD_BEN),
      .sr1_out  (sr1_out),
      .sr2_out  (sr2_out),
      .nzp      (nzp),
      .ben      (ben)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Apply one rising edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] idx, input logic [15:0] exp);
      sr1_addr = idx;
      #1;
      check(tag, {16'h0, sr1_out}, {16'h0, exp});
   endtask

   initial begin
      Reset = 1'b1; ir = 16'h0000; bus = 16'hFFFF; sr1_addr = 3'd0;
      DRMUX = 1'b0; LD_REG = 1'b1; LD_CC = 1'b1; LD_BEN = 1'b1;

      // 1: reset dominates all loads
      tick();
      tick();
      Reset = 1'b0; LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0;
      for (int i = 0; i < 8; i++) check_reg($sformatf("rst_R%0d", i), 3'(i), 16'h0000);
      check("rst_nzp", {29'h0, nzp}, 32'h0);
      check("rst_ben", {31'h0, ben}, 32'h0);

      // 2: write R3 via ir[11:9], no bypass during the write cycle
      ir = 16'h0600; DRMUX = 1'b0; bus = 16'h1234; LD_REG = 1'b1; sr1_addr = 3'd3;
      #1;
      check("r3_prewrite", {16'h0, sr1_out}, 32'h0);
      tick();
      LD_REG = 1'b0;
      check_reg("r3_written", 3'd3, 16'h1234);
      for (int i = 0; i < 8; i++)
         if (i != 3) check_reg($sformatf("r3_other_R%0d", i), 3'(i), 16'h0000);

      // 3: DRMUX forces R7
      ir = 16'h0400; DRMUX = 1'b1; bus = 16'h00A5; LD_REG = 1'b1;
      tick();
      LD_REG = 1'b0; DRMUX = 1'b0;
      check_reg("drmux_R7", 3'd7, 16'h00A5);
      check_reg("drmux_R2", 3'd2, 16'h0000);
      check_reg("drmux_R3", 3'd3, 16'h1234);

      // 4: NZP classification
      LD_CC = 1'b1; bus = 16'h8000; tick();
      check("nzp_neg", {29'h0, nzp}, 32'h4);
      bus = 16'h0000; tick();
      check("nzp_zero", {29'h0, nzp}, 32'h2);
      bus = 16'h7FFF; tick();
      check("nzp_pos", {29'h0, nzp}, 32'h1);
      bus = 16'h0100; tick();
      check("nzp_pos_hibyte", {29'h0, nzp}, 32'h1);
      LD_CC = 1'b0; bus = 16'h0000; tick();
      check("nzp_hold", {29'h0, nzp}, 32'h1);

      // 5: BEN uses old nzp when LD_CC fires in the same cycle
      LD_CC = 1'b1; bus = 16'h0000; tick();
      check("ben_setup_nzp", {29'h0, nzp}, 32'h2);
      ir = 16'h0400; bus = 16'h0001; LD_BEN = 1'b1; LD_CC = 1'b1; tick();
      check("ben_old_z", {31'h0, ben}, 32'h1);
      check("ben_nzp_new", {29'h0, nzp}, 32'h1);
      LD_CC = 1'b0; tick();
      check("ben_clear", {31'h0, ben}, 32'h0);
      ir = 16'h0200; tick();
      check("ben_p", {31'h0, ben}, 32'h1);
      LD_BEN = 1'b0; ir = 16'h0000; tick();
      check("ben_hold", {31'h0, ben}, 32'h1);

      // 6: write R5, then reset with a pending write to R5
      ir = 16'h0A05; bus = 16'hBEEF; LD_REG = 1'b1; tick();
      LD_REG = 1'b0;
      check("r5_sr2", {16'h0, sr2_out}, 32'hBEEF);
      sr1_addr = 3'd5; #1;
      check("r5_sr1_same", {16'h0, sr1_out}, 32'hBEEF);
      Reset = 1'b1; LD_REG = 1'b1; bus = 16'h1111; tick();
      Reset = 1'b0; LD_REG = 1'b0; #1;
      check("rst_r5_sr2", {16'h0, sr2_out}, 32'h0);
      check_reg("rst_R7", 3'd7, 16'h0000);
      check("rst2_nzp", {29'h0, nzp}, 32'h0);
      check("rst2_ben", {31'h0, ben}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
